// File: rtl/game_pkg.sv
// Shared constants for the whack-a-mole datapath: the game state encoding and a
// width helper for the seconds counters.
package game_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE         = 3'd0,
        ST_START_SCREEN = 3'd1,
        ST_PREROLL      = 3'd2,
        ST_IN_GAME      = 3'd3,
        ST_PAUSED       = 3'd4,
        ST_GAME_OVER    = 3'd5
    } game_state_e;

    // Width of a down-counter holding 0..max_value; never narrower than one bit.
    function automatic int count_w(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/game_controller_second_ticker.sv
// One-second timebase: prescaler advances while run is high and ticks on its
// last count. Clear restarts the second; freezing run holds the count.
module second_ticker #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int              CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= (r_count == LAST) ? '0 : r_count + CNT_W'(1);
        end
    end

    assign tick = run && (r_count == LAST);

endmodule

// File: rtl/game_controller.sv
// Top-level game sequencer: state machine, pre-roll and game timers, score with
// saturation and miss penalty, and persistent high score.
module game_controller
    import game_pkg::*;
#(
    parameter int NUM_MOLES       = 5,
    parameter int CLK_HZ          = 50_000_000,
    parameter int GAME_SECONDS    = 60,
    parameter int PREROLL_SECONDS = 3,
    parameter int SCORE_W         = 8,
    parameter int MISS_PENALTY    = 0
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  pause,
    input  logic                                  hit,
    input  logic                                  miss,
    output logic [STATE_W-1:0]                    current_state,
    output logic [SCORE_W-1:0]                    score,
    output logic [SCORE_W-1:0]                    high_score,
    output logic                                  new_high,
    output logic [count_w(GAME_SECONDS)-1:0]      time_left,
    output logic [count_w(PREROLL_SECONDS)-1:0]   preroll_left,
    output logic                                  gen_enable,
    output logic [NUM_MOLES-1:0]                  mole_clear_mask,
    output logic                                  game_over_pulse
);

    localparam int TIME_W = count_w(GAME_SECONDS);
    localparam int PRE_W  = count_w(PREROLL_SECONDS);
    localparam int PEN_W  = count_w(MISS_PENALTY);
    localparam int SUM_W  = ((SCORE_W > PEN_W) ? SCORE_W : PEN_W) + 1;

    localparam logic [SUM_W-1:0] PEN       = SUM_W'(MISS_PENALTY);
    localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'({SCORE_W{1'b1}});

    game_state_e         r_state;
    game_state_e         w_next;
    logic [SCORE_W-1:0]  r_score;
    logic [SCORE_W-1:0]  r_high_score;
    logic                r_new_high;
    logic [TIME_W-1:0]   r_time_left;
    logic [PRE_W-1:0]    r_preroll_left;
    logic                r_gen_enable;
    logic [NUM_MOLES-1:0] r_clear_mask;
    logic                r_game_over_pulse;

    logic                w_tick;
    logic                w_run;
    logic                w_clear;
    logic                w_final_tick;
    logic                w_enter_preroll;
    logic                w_enter_game;
    logic                w_enter_over;
    logic [SUM_W-1:0]    w_sum;
    logic [SUM_W-1:0]    w_pen;
    logic [SCORE_W-1:0]  w_score_upd;

    second_ticker #(
        .CLK_HZ (CLK_HZ)
    ) u_ticker (
        .clock (clock),
        .reset (reset),
        .run   (w_run),
        .clear (w_clear),
        .tick  (w_tick)
    );

    assign w_final_tick = w_tick && (r_time_left == TIME_W'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:         w_next = ST_START_SCREEN;
            ST_START_SCREEN: if (start) w_next = ST_PREROLL;
            ST_PREROLL:      if (r_preroll_left == '0) w_next = ST_IN_GAME;
            // The final tick outranks a simultaneous pause.
            ST_IN_GAME: begin
                if (w_final_tick) begin
                    w_next = ST_GAME_OVER;
                end else if (pause) begin
                    w_next = ST_PAUSED;
                end
            end
            ST_PAUSED:       if (pause) w_next = ST_IN_GAME;
            ST_GAME_OVER:    if (start) w_next = ST_START_SCREEN;
            default:         w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_enter_preroll = (r_state == ST_START_SCREEN) && (w_next == ST_PREROLL);
        w_enter_game    = (r_state == ST_PREROLL) && (w_next == ST_IN_GAME);
        w_enter_over    = (r_state == ST_IN_GAME) && (w_next == ST_GAME_OVER);
        w_clear         = w_enter_preroll || w_enter_game;
        w_run           = (r_state == ST_PREROLL) || (r_state == ST_IN_GAME);
    end

    // Hit and penalty are applied as one signed step, then clamped to [0, max].
    always_comb begin
        w_sum       = SUM_W'(r_score) + SUM_W'(hit);
        w_pen       = (miss && (MISS_PENALTY != 0)) ? PEN : '0;
        w_score_upd = r_score;
        if (w_sum < w_pen) begin
            w_score_upd = '0;
        end else if ((w_sum - w_pen) > SCORE_MAX) begin
            w_score_upd = '1;
        end else begin
            w_score_upd = SCORE_W'(w_sum - w_pen);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_score           <= '0;
            r_high_score      <= '0;
            r_new_high        <= 1'b0;
            r_time_left       <= '0;
            r_preroll_left    <= '0;
            r_gen_enable      <= 1'b0;
            r_clear_mask      <= '0;
            r_game_over_pulse <= 1'b0;
        end else begin
            if (w_enter_preroll) begin
                r_preroll_left <= PRE_W'(PREROLL_SECONDS);
            end else if ((r_state == ST_PREROLL) && w_tick && (r_preroll_left != '0)) begin
                r_preroll_left <= r_preroll_left - PRE_W'(1);
            end

            if (w_enter_game) begin
                r_time_left <= TIME_W'(GAME_SECONDS);
            end else if ((r_state == ST_IN_GAME) && w_tick) begin
                r_time_left <= r_time_left - TIME_W'(1);
            end

            if (w_enter_preroll) begin
                r_score <= '0;
            end else if (r_state == ST_IN_GAME) begin
                r_score <= w_score_upd;
            end

            // High-score compare sees the score including a hit on the final tick.
            if (w_enter_over && (w_score_upd > r_high_score)) begin
                r_high_score <= w_score_upd;
            end
            r_new_high <= w_enter_over ? (w_score_upd > r_high_score)
                                       : (r_new_high && (w_next == ST_GAME_OVER));

            r_gen_enable      <= (w_next == ST_IN_GAME);
            r_clear_mask      <= w_enter_preroll ? '1 : '0;
            r_game_over_pulse <= w_enter_over;
        end
    end

    assign current_state   = r_state;
    assign score           = r_score;
    assign high_score      = r_high_score;
    assign new_high        = r_new_high;
    assign time_left       = r_time_left;
    assign preroll_left    = r_preroll_left;
    assign gen_enable      = r_gen_enable;
    assign mole_clear_mask = r_clear_mask;
    assign game_over_pulse = r_game_over_pulse;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: two instances (3 s and 12 s games) checked every
// cycle against a behavioural model, plus directed scenarios with literal values.
module tb_game_controller;

    localparam int HZ   = 4;
    localparam int PRE  = 2;
    localparam int PEN  = 1;
    localparam int SMAX = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] s_start = '0;
    logic [1:0] s_pause = '0;
    logic [1:0] s_hit   = '0;
    logic [1:0] s_miss  = '0;

    logic [2:0] a_state, b_state;
    logic [3:0] a_score, b_score, a_high, b_high;
    logic       a_nh, b_nh, a_gen, b_gen, a_gop, b_gop;
    logic [1:0] a_time;
    logic [3:0] b_time;
    logic [1:0] a_pre, b_pre;
    logic [4:0] a_mask, b_mask;

    int n_checks = 0;
    int n_errors = 0;

    int m_state[2], m_score[2], m_high[2], m_nh[2], m_time[2];
    int m_pre[2], m_phase[2], m_mask[2], m_gop[2], m_gen[2];

    always #5 clk = ~clk;

    game_controller #(
        .NUM_MOLES(5), .CLK_HZ(HZ), .GAME_SECONDS(3), .PREROLL_SECONDS(PRE),
        .SCORE_W(4), .MISS_PENALTY(PEN)
    ) u_dut_a (
        .clock(clk), .reset(rst), .start(s_start[0]), .pause(s_pause[0]),
        .hit(s_hit[0]), .miss(s_miss[0]), .current_state(a_state), .score(a_score),
        .high_score(a_high), .new_high(a_nh), .time_left(a_time), .preroll_left(a_pre),
        .gen_enable(a_gen), .mole_clear_mask(a_mask), .game_over_pulse(a_gop)
    );

    game_controller #(
        .NUM_MOLES(5), .CLK_HZ(HZ), .GAME_SECONDS(12), .PREROLL_SECONDS(PRE),
        .SCORE_W(4), .MISS_PENALTY(PEN)
    ) u_dut_b (
        .clock(clk), .reset(rst), .start(s_start[1]), .pause(s_pause[1]),
        .hit(s_hit[1]), .miss(s_miss[1]), .current_state(b_state), .score(b_score),
        .high_score(b_high), .new_high(b_nh), .time_left(b_time), .preroll_left(b_pre),
        .gen_enable(b_gen), .mole_clear_mask(b_mask), .game_over_pulse(b_gop)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int game_len(input int i);
        return (i == 0) ? 3 : 12;
    endfunction

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > SMAX) ? SMAX : v);
    endfunction

    // Behavioural model: one call per clock edge, working in seconds and cycle phase.
    task automatic model_step(input int i);
        int  ns;
        bit  tk;
        ns = m_state[i];
        tk = ((m_state[i] == 2) || (m_state[i] == 3)) && (m_phase[i] == HZ - 1);
        m_mask[i] = 0;
        m_gop[i]  = 0;
        case (m_state[i])
            0: ns = 1;
            1: if (s_start[i]) begin
                ns = 2; m_score[i] = 0; m_pre[i] = PRE; m_phase[i] = 0; m_mask[i] = 31;
            end
            2: if (m_pre[i] == 0) begin
                ns = 3; m_time[i] = game_len(i); m_phase[i] = 0;
            end else begin
                if (tk) m_pre[i] = m_pre[i] - 1;
                m_phase[i] = (m_phase[i] + 1) % HZ;
            end
            3: begin
                m_score[i] = clamp(m_score[i] + int'(s_hit[i]) - (s_miss[i] ? PEN : 0));
                m_phase[i] = (m_phase[i] + 1) % HZ;
                if (tk) m_time[i] = m_time[i] - 1;
                if (tk && (m_time[i] == 0)) begin
                    ns = 5; m_gop[i] = 1;
                    m_nh[i] = (m_score[i] > m_high[i]) ? 1 : 0;
                    if (m_score[i] > m_high[i]) m_high[i] = m_score[i];
                end else if (s_pause[i]) begin
                    ns = 4;
                end
            end
            4: if (s_pause[i]) ns = 3;
            5: if (s_start[i]) ns = 1;
            default: ns = 0;
        endcase
        if (ns != 5) m_nh[i] = 0;
        m_gen[i]   = (ns == 3) ? 1 : 0;
        m_state[i] = ns;
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_state[i] = 0; m_score[i] = 0; m_high[i] = 0; m_nh[i] = 0; m_time[i] = 0;
                m_pre[i] = 0; m_phase[i] = 0; m_mask[i] = 0; m_gop[i] = 0; m_gen[i] = 0;
            end else begin
                model_step(i);
            end
        end
    end

    task automatic cmp_inst(input int i, input logic [31:0] st, sc, hi, nh, tl, pl, ge, mk, gp);
        check($sformatf("i%0d state", i), st, m_state[i]);
        check($sformatf("i%0d score", i), sc, m_score[i]);
        check($sformatf("i%0d high_score", i), hi, m_high[i]);
        check($sformatf("i%0d new_high", i), nh, m_nh[i]);
        check($sformatf("i%0d time_left", i), tl, m_time[i]);
        check($sformatf("i%0d preroll_left", i), pl, m_pre[i]);
        check($sformatf("i%0d gen_enable", i), ge, m_gen[i]);
        check($sformatf("i%0d clear_mask", i), mk, m_mask[i]);
        check($sformatf("i%0d game_over_pulse", i), gp, m_gop[i]);
    endtask

    always @(negedge clk) begin
        cmp_inst(0, a_state, a_score, a_high, a_nh, a_time, a_pre, a_gen, a_mask, a_gop);
        cmp_inst(1, b_state, b_score, b_high, b_nh, b_time, b_pre, b_gen, b_mask, b_gop);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int i, input logic st, input logic pa, input logic hi, input logic mi);
        s_start[i] = st; s_pause[i] = pa; s_hit[i] = hi; s_miss[i] = mi;
        step(1);
        s_start[i] = 1'b0; s_pause[i] = 1'b0; s_hit[i] = 1'b0; s_miss[i] = 1'b0;
    endtask

    function automatic int dut_state(input int i);
        return (i == 0) ? int'(a_state) : int'(b_state);
    endfunction

    task automatic wait_state(input int i, input int target, input int budget, output int n);
        n = 0;
        while ((dut_state(i) != target) && (n < budget)) begin
            step(1);
            n++;
        end
        check($sformatf("i%0d wait for state %0d", i, target), dut_state(i), target);
    endtask

    task automatic play_game(input int i, input int nhits);
        int n;
        if (dut_state(i) == 5) drive(i, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(i, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_state(i, 3, 30, n);
        repeat (nhits) drive(i, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_state(i, 5, 80, n);
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, " state"}, a_state, 0);
        check({tag, " score"}, a_score, 0);
        check({tag, " high"}, a_high, 0);
        check({tag, " new_high"}, a_nh, 0);
        check({tag, " time_left"}, a_time, 0);
        check({tag, " preroll_left"}, a_pre, 0);
        check({tag, " gen_enable"}, a_gen, 0);
        check({tag, " mask"}, a_mask, 0);
        check({tag, " go_pulse"}, a_gop, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int saved_time;
        // Reset, then IDLE -> START_SCREEN.
        step(2);
        check_a_zero("reset");
        rst = 1'b0;
        step(1);
        check("start screen", a_state, 1);

        // Pre-roll: clear mask for one cycle, countdown 2 -> 1 -> 0 at 4-cycle spacing.
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("preroll entry", a_state, 2);
        check("clear mask on", a_mask, 5'b11111);
        check("preroll load", a_pre, 2);
        step(1);
        check("clear mask off", a_mask, 0);
        step(2);
        check("preroll 2 held", a_pre, 2);
        step(1);
        check("preroll to 1", a_pre, 1);
        step(4);
        check("preroll to 0", a_pre, 0);
        check("still preroll", a_state, 2);
        step(1);
        check("in game", a_state, 3);
        check("time load", a_time, 3);
        check("gen on", a_gen, 1);

        // First game: 5 hits, length exactly 12 cycles.
        repeat (5) drive(0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_state(0, 5, 30, n);
        check("game length", 5 + n, 12);
        check("go pulse", a_gop, 1);
        check("game1 score", a_score, 5);
        check("game1 high", a_high, 5);
        check("game1 new_high", a_nh, 1);
        check("model score pin", m_score[0], 5);
        check("model high pin", m_high[0], 5);
        step(1);
        check("go pulse one cycle", a_gop, 0);
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("back to start screen", a_state, 1);
        check("new_high cleared", a_nh, 0);

        // Lower and equal scores leave the high score alone.
        play_game(0, 3);
        check("game2 score", a_score, 3);
        check("game2 high", a_high, 5);
        check("game2 new_high", a_nh, 0);
        play_game(0, 5);
        check("equal score new_high", a_nh, 0);
        check("equal score high", a_high, 5);

        // Combined hit+miss at 7 stays 7; a lone miss costs one point.
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_state(0, 3, 30, n);
        repeat (7) drive(0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("score 7", a_score, 7);
        drive(0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("hit+miss", a_score, 7);
        drive(0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("miss penalty", a_score, 6);
        wait_state(0, 5, 30, n);
        check("game3 high", a_high, 6);

        // Pause after 6 active cycles for 10 cycles with hits.
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_state(0, 3, 30, n);
        repeat (2) drive(0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3);
        saved_time = a_time;
        check("time before pause", saved_time, 2);
        drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("paused", a_state, 4);
        for (int k = 0; k < 9; k++) begin
            drive(0, 1'b0, 1'b0, 1'b1, 1'b0);
            check("paused time", a_time, saved_time);
            check("paused score", a_score, 2);
            check("paused gen", a_gen, 0);
        end
        drive(0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("resumed", a_state, 3);
        check("resume score", a_score, 2);
        wait_state(0, 5, 30, n);
        check("resume remainder", n, 12 - 6);

        play_game(0, 9);
        check("high 9", a_high, 9);

        // Saturation and floor on the 12-second instance.
        drive(1, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_state(1, 3, 30, n);
        repeat (20) drive(1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("saturate 15", b_score, 15);
        repeat (20) drive(1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("floor 0", b_score, 0);
        check("model floor pin", m_score[1], 0);
        wait_state(1, 5, 80, n);
        check("b new_high zero score", b_nh, 0);

        // Reset mid-game with score 4 and high score 9.
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_state(0, 3, 30, n);
        repeat (4) drive(0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("pre-reset score", a_score, 4);
        check("pre-reset high", a_high, 9);
        rst = 1'b1;
        step(1);
        check_a_zero("mid-game reset");
        rst = 1'b0;

        // Random traffic on both instances, checked every cycle by the model.
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 699) == 0);
            for (int i = 0; i < 2; i++) begin
                s_start[i] = ($urandom_range(0, 9) == 0);
                s_pause[i] = ($urandom_range(0, 11) == 0);
                s_hit[i]   = ($urandom_range(0, 2) == 0);
                s_miss[i]  = ($urandom_range(0, 3) == 0);
            end
            step(1);
        end
        rst = 1'b0;
        s_start = '0; s_pause = '0; s_hit = '0; s_miss = '0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/game_controller.md
# game_controller

Parametrised top-level game sequencer for the whack-a-mole datapath; successor to the fixed-size main FSM. Sequences idle, start screen, pre-roll countdown, in-game, pause and game-over. Owns the one-second timebase, game timer, score (hit credit plus optional miss penalty) and persistent high score. Drives the mole generator enable and clear, and feeds score and time to the display path.

## Interface
Parameters:
- `NUM_MOLES`, 5: mole positions; width of `mole_clear_mask`.
- `CLK_HZ`, 50_000_000: clock cycles per one-second tick.
- `GAME_SECONDS`, 60: game length; must be ≥1.
- `PREROLL_SECONDS`, 3: countdown before play; 0 allowed.
- `SCORE_W`, 8: width of score and high score.
- `MISS_PENALTY`, 0: points subtracted per miss; 0 disables penalty mode.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle pulse.
- `pause` in 1: single-cycle toggle pulse.
- `hit` in 1: pulse, one successful hit from match logic.
- `miss` in 1: pulse, one miss from match logic.
- `current_state` out 3: encoded state.
- `score` out SCORE_W: current score.
- `high_score` out SCORE_W: best score since reset.
- `new_high` out 1: high while in GAME_OVER if last game set a new high.
- `time_left` out $clog2(GAME_SECONDS+1): seconds remaining.
- `preroll_left` out $clog2(PREROLL_SECONDS+1): pre-roll seconds remaining.
- `gen_enable` out 1: mole generator enable.
- `mole_clear_mask` out NUM_MOLES: all-ones for one cycle on entering PREROLL, otherwise zero.
- `game_over_pulse` out 1: one cycle on entering GAME_OVER.

## Operation
- State encoding: IDLE=0, START_SCREEN=1, PREROLL=2, IN_GAME=3, PAUSED=4, GAME_OVER=5. Unused codes go to IDLE.
- IDLE → START_SCREEN unconditionally.
- START_SCREEN + `start` → PREROLL.
  - On the transition: clear score, load `preroll_left`=PREROLL_SECONDS, clear prescaler.
- PREROLL: decrement `preroll_left` on each tick.
  - When `preroll_left` is 0 (immediately if PREROLL_SECONDS=0) → IN_GAME.
  - On entry to IN_GAME: load `time_left`=GAME_SECONDS, clear prescaler.
- IN_GAME: decrement `time_left` on each tick.
  - Tick while `time_left`=1 → GAME_OVER.
  - `pause` → PAUSED.
- PAUSED: prescaler and timer frozen; hit/miss ignored. `pause` → IN_GAME with prescaler resumed, not cleared. `start` ignored.
- GAME_OVER + `start` → START_SCREEN. `pause` ignored.
- `gen_enable`=1 only in IN_GAME.
- Scoring, IN_GAME only: hit adds 1 and miss subtracts MISS_PENALTY, combined in one step. Result saturates at 0 and at 2^SCORE_W−1. Hit/miss in any other state is ignored.
- High score: on entry to GAME_OVER, if score > high_score (strict), load high_score and set `new_high`. `new_high` clears on leaving GAME_OVER. Only reset clears high_score.
- `reset` has priority over every input, in any state including mid-game.

## Timing
- Reset values: state IDLE; score, high_score, time_left, preroll_left = 0; new_high, gen_enable, mole_clear_mask, game_over_pulse = 0; prescaler 0.
- All outputs are registered. `current_state` changes one cycle after the qualifying input.
- Tick asserts when prescaler = CLK_HZ−1, then the prescaler wraps to 0. One tick per CLK_HZ cycles in PREROLL/IN_GAME.
- Score updates the cycle after the hit/miss pulse.
- A hit on the same cycle as the final tick is counted. The GAME_OVER high-score compare uses the updated score.
- `pause` and the final tick on the same cycle: the tick wins (GAME_OVER).
- `start` and `pause` on the same cycle in START_SCREEN: `start` wins.

## Structure
- Shared package `game_pkg`: state encoding constants and a width helper for `time_left`/`preroll_left`. The mole generator and display decoder import the same constants.
- Sub-module `second_ticker`:
  - Parameter CLK_HZ.
  - Inputs `clock`, `reset`, `run`, `clear`; output `tick`.
  - Prescaler lives here.
- FSM, timers and score logic live in `game_controller`.

## Test plan
Bench parameters: CLK_HZ=4, GAME_SECONDS=3, PREROLL_SECONDS=2, SCORE_W=4, MISS_PENALTY=1.
- Reset, then `start` in START_SCREEN:
  - PREROLL with `mole_clear_mask`=5'b11111 for one cycle.
  - preroll_left 2→1→0 at 4-cycle spacing, then IN_GAME with time_left=3 and gen_enable=1.
- Full game with 5 hits and no pause:
  - GAME_OVER exactly 12 cycles after IN_GAME entry; game_over_pulse one cycle.
  - score=5, high_score=5, new_high=1.
- Second game with 3 hits:
  - score=3, high_score stays 5, new_high=0.
  - Repeat with 5 hits: equal score gives new_high=0.
- Score saturation and floor:
  - 20 hits → score 15.
  - Then 20 misses → score 0.
  - hit+miss on the same cycle at score 7 → 7.
- Pause in IN_GAME for 10 cycles with hit pulses:
  - time_left and score unchanged; gen_enable=0.
  - After resume, the remaining game length equals the pre-pause remainder.
- Reset asserted mid-IN_GAME with score 4, high_score 9: next cycle IDLE, all outputs 0, including high_score.
